stripe_pattern_generator: RTL and testbench

STRIPE_PATTERN_GENERATOR -- requirements
Module: stripe_pattern_generator

---
 rtl/pattern_gen_pkg.sv | 13 +
 rtl/raster_counter.sv | 58 +++++
 rtl/stripe_pattern_generator.sv | 185 ++++++++++++++++++
 tb/tb_stripe_pattern_generator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_gen_pkg.sv
// Shared types and default levels for the stripe pattern generator.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  localparam logic [7:0] DEF_WHITE_LEVEL = 8'd255;
  localparam logic [7:0] DEF_BLACK_LEVEL = 8'd0;

endpackage

// File: rtl/raster_counter.sv
// Column/row raster position for one frame, advanced once per accepted beat.
module raster_counter #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int XW     = 9,
  parameter int YW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sof,
  output logic          eol,
  output logic          eof
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          last_col, last_row;

  assign last_col = (x_q == XW'(WIDTH - 1));
  assign last_row = (y_q == YW'(HEIGHT - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (last_col) begin
        x_d = '0;
        y_d = last_row ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x   = x_q;
  assign y   = y_q;
  assign sof = (x_q == '0) && (y_q == '0);
  assign eol = last_col;
  assign eof = last_col && last_row;

endmodule

// File: rtl/stripe_pattern_generator.sv
// Horizontal stripe test-pattern source with ready/valid output and frame sequencing.
// state     | meaning
// ST_IDLE   | waiting for start, outputs quiet
// ST_ACTIVE | streaming one frame
// ST_GAP    | FRAME_GAP idle cycles, then next frame or IDLE
module stripe_pattern_generator
  import pattern_gen_pkg::*;
#(
  parameter int          IMG_WIDTH   = 320,
  parameter int          IMG_HEIGHT  = 240,
  parameter int          W           = 8,
  parameter logic [W-1:0] WHITE_LEVEL = W'(DEF_WHITE_LEVEL),
  parameter logic [W-1:0] BLACK_LEVEL = W'(DEF_BLACK_LEVEL),
  parameter int          FRAME_GAP   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         continuous,
  input  logic         stop,
  input  logic [7:0]   y_start,
  input  logic [7:0]   stripe_height,
  input  logic [7:0]   gap_height,
  input  logic [3:0]   num_stripes,
  input  logic [8:0]   x_start,
  input  logic [8:0]   x_end,
  output logic         y_valid,
  input  logic         y_ready,
  output logic [W-1:0] y_data,
  output logic         sof,
  output logic         eol,
  output logic         eof,
  output logic         busy,
  output logic [15:0]  frame_count
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  state_e        state_q, state_d;
  logic          stop_q, stop_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   fc_q, fc_d;
  logic [7:0]    ys_q, ys_d, sh_q, sh_d, gh_q, gh_d;
  logic [3:0]    ns_q, ns_d, idx_q, idx_d;
  logic [8:0]    xs_q, xs_d, xe_q, xe_d, phase_q, phase_d;

  logic          beat, frame_start, row_started, row_white, col_white;
  logic [8:0]    period, phase_inc;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_sof, r_eol, r_eof;

  assign y_valid = (state_q == ST_ACTIVE);
  assign beat    = y_valid && y_ready;

  raster_counter #(
    .WIDTH (IMG_WIDTH),
    .HEIGHT(IMG_HEIGHT),
    .XW    (XW),
    .YW    (YW)
  ) u_raster (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (frame_start),
    .advance(beat),
    .x      (r_x),
    .y      (r_y),
    .sof    (r_sof),
    .eol    (r_eol),
    .eof    (r_eof)
  );

  // Row phase within a stripe period and stripe index replace k mod / k div.
  assign period      = {1'b0, sh_q} + {1'b0, gh_q};
  assign phase_inc   = phase_q + 9'd1;
  assign row_started = 16'(r_y) >= 16'(ys_q);
  assign row_white   = row_started && (idx_q < ns_q) && (phase_q < {1'b0, sh_q});
  assign col_white   = (16'(r_x) >= 16'(xs_q)) && (16'(r_x) <= 16'(xe_q));

  always_comb begin
    state_d     = state_q;
    stop_d      = stop_q;
    gap_d       = gap_q;
    fc_d        = fc_q;
    ys_d        = ys_q;
    sh_d        = sh_q;
    gh_d        = gh_q;
    ns_d        = ns_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    frame_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_ACTIVE;
          stop_d      = 1'b0;
          frame_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (stop) stop_d = 1'b1;
        if (beat && r_eof) begin
          state_d = ST_GAP;
          gap_d   = GW'(FRAME_GAP - 1);
          fc_d    = fc_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (stop) stop_d = 1'b1;
        if (gap_q == '0) begin
          if (continuous && !stop_q && !stop) begin
            state_d     = ST_ACTIVE;
            frame_start = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_start) begin
      ys_d    = y_start;
      sh_d    = stripe_height;
      gh_d    = gap_height;
      ns_d    = num_stripes;
      xs_d    = x_start;
      xe_d    = x_end;
      phase_d = '0;
      idx_d   = '0;
    end else if (beat && r_eol && row_started) begin
      if (phase_inc == period) begin
        phase_d = '0;
        if (idx_q != 4'hF) idx_d = idx_q + 4'd1;
      end else begin
        phase_d = phase_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stop_q  <= 1'b0;
      gap_q   <= '0;
      fc_q    <= '0;
      ys_q    <= '0;
      sh_q    <= '0;
      gh_q    <= '0;
      ns_q    <= '0;
      xs_q    <= '0;
      xe_q    <= '0;
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      gap_q   <= gap_d;
      fc_q    <= fc_d;
      ys_q    <= ys_d;
      sh_q    <= sh_d;
      gh_q    <= gh_d;
      ns_q    <= ns_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  assign y_data      = !y_valid ? '0 : ((row_white && col_white) ? WHITE_LEVEL : BLACK_LEVEL);
  assign sof         = y_valid && r_sof;
  assign eol         = y_valid && r_eol;
  assign eof         = y_valid && r_eof;
  assign busy        = (state_q != ST_IDLE);
  assign frame_count = fc_q;

endmodule

// File: tb/tb_stripe_pattern_generator.sv
// Directed bench for stripe_pattern_generator; a narrow 16-pixel line keeps frames short.
module tb_stripe_pattern_generator;

  localparam int TW = 16;
  localparam int TH = 240;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        stop = 1'b0;
  logic        y_ready = 1'b1;
  logic [7:0]  y_start = '0;
  logic [7:0]  stripe_height = '0;
  logic [7:0]  gap_height = '0;
  logic [3:0]  num_stripes = '0;
  logic [8:0]  x_start = '0;
  logic [8:0]  x_end = '0;
  logic        y_valid, sof, eol, eof, busy;
  logic [7:0]  y_data;
  logic [15:0] frame_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stripe_pattern_generator #(
    .IMG_WIDTH (TW),
    .IMG_HEIGHT(TH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .continuous   (continuous),
    .stop         (stop),
    .y_start      (y_start),
    .stripe_height(stripe_height),
    .gap_height   (gap_height),
    .num_stripes  (num_stripes),
    .x_start      (x_start),
    .x_end        (x_end),
    .y_valid      (y_valid),
    .y_ready      (y_ready),
    .y_data       (y_data),
    .sof          (sof),
    .eol          (eol),
    .eof          (eof),
    .busy         (busy),
    .frame_count  (frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Direct div/mod formulation of the stripe rule.
  function automatic logic [7:0] exp_pix(input int x, input int r);
    int k, p;
    if (r < int'(y_start) || stripe_height == 0 || num_stripes == 0) return 8'd0;
    k = r - int'(y_start);
    p = int'(stripe_height) + int'(gap_height);
    if (k / p >= int'(num_stripes)) return 8'd0;
    if (k % p >= int'(stripe_height)) return 8'd0;
    if (x < int'(x_start) || x > int'(x_end)) return 8'd0;
    return 8'd255;
  endfunction

  task automatic set_cfg(input int ys, input int sh, input int gh, input int ns,
                         input int xs, input int xe);
    y_start       = 8'(ys);
    stripe_height = 8'(sh);
    gap_height    = 8'(gh);
    num_stripes   = 4'(ns);
    x_start       = 9'(xs);
    x_end         = 9'(xe);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic count_gap(input int exp_len);
    int g = 0;
    while (!y_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("gap_len", g, exp_len);
  endtask

  task automatic run_frame(input bit bp, input int stop_at, output int beats,
                           output int white, output int fw, output int lw);
    int bx, br;
    bit done, prev_stall;
    logic [7:0] s_data, e;
    logic s_sof, s_eol, s_eof;
    beats = 0; white = 0; fw = -1; lw = -1;
    bx = 0; br = 0; done = 0; prev_stall = 0;
    s_data = '0; s_sof = 0; s_eol = 0; s_eof = 0;
    for (int c = 0; c < 20000 && !done; c++) begin
      y_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stop    = (beats == stop_at);
      if (prev_stall) begin
        chk("stall_data", 32'(y_data), 32'(s_data));
        chk("stall_sof", 32'(sof), 32'(s_sof));
        chk("stall_eol", 32'(eol), 32'(s_eol));
        chk("stall_eof", 32'(eof), 32'(s_eof));
      end
      if (y_valid && y_ready) begin
        e = exp_pix(bx, br);
        chk("pixel", 32'(y_data), 32'(e));
        chk("sof", 32'(sof), 32'(bx == 0 && br == 0));
        chk("eol", 32'(eol), 32'(bx == TW - 1));
        chk("eof", 32'(eof), 32'(bx == TW - 1 && br == TH - 1));
        if (y_data == 8'd255) begin
          white++;
          if (fw < 0) fw = br;
          lw = br;
        end
        beats++;
        done = (bx == TW - 1 && br == TH - 1);
        if (bx == TW - 1) begin
          bx = 0;
          br++;
        end else begin
          bx++;
        end
      end
      prev_stall = y_valid && !y_ready;
      s_data = y_data; s_sof = sof; s_eol = eol; s_eof = eof;
      @(negedge clk);
    end
    stop    = 1'b0;
    y_ready = 1'b1;
    chk("frame_done", 32'(done), 32'd1);
  endtask

  initial begin
    int b, w, f, l;

    // Reset state
    #12;
    chk("rst_valid", 32'(y_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(y_data), 32'd0);
    chk("rst_flags", {29'd0, sof, eol, eof}, 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_valid", 32'(y_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Three 20-row stripes from row 10, full width
    set_cfg(10, 20, 20, 3, 0, 319);
    pulse_start();
    chk("valid_after_start", 32'(y_valid), 32'd1);
    chk("busy_active", 32'(busy), 32'd1);
    run_frame(1'b0, -1, b, w, f, l);
    chk("f1_beats", b, 3840);
    chk("f1_white", w, 960);
    chk("f1_first", f, 10);
    chk("f1_last", l, 109);
    chk("f1_fc", 32'(frame_count), 32'd1);
    chk("f1_gap_valid", 32'(y_valid), 32'd0);
    chk("f1_gap_busy", 32'(busy), 32'd1);

    // start during GAP is ignored
    pulse_start();
    wait_idle();
    repeat (5) @(negedge clk);
    chk("start_ignored", 32'(y_valid), 32'd0);

    // Same frame under random backpressure
    pulse_start();
    run_frame(1'b1, -1, b, w, f, l);
    chk("bp_beats", b, 3840);
    chk("bp_white", w, 960);
    chk("bp_first", f, 10);
    chk("bp_last", l, 109);
    chk("bp_fc", 32'(frame_count), 32'd2);

    // Continuous, stop pulsed mid second frame
    wait_idle();
    continuous = 1'b1;
    pulse_start();
    run_frame(1'b0, -1, b, w, f, l);
    chk("c1_fc", 32'(frame_count), 32'd3);
    count_gap(16);
    run_frame(1'b0, 500, b, w, f, l);
    chk("c2_beats", b, 3840);
    chk("c2_white", w, 960);
    chk("c2_fc", 32'(frame_count), 32'd4);
    wait_idle();
    repeat (30) @(negedge clk);
    chk("c_stays_idle", 32'(y_valid), 32'd0);
    chk("c_idle_fc", 32'(frame_count), 32'd4);
    continuous = 1'b0;

    // All-black cases
    set_cfg(10, 20, 20, 0, 0, 319);
    pulse_start();
    run_frame(1'b0, -1, b, w, f, l);
    chk("ns0_white", w, 0);
    wait_idle();
    set_cfg(10, 0, 20, 3, 0, 319);
    pulse_start();
    run_frame(1'b0, -1, b, w, f, l);
    chk("sh0_white", w, 0);
    wait_idle();
    set_cfg(10, 20, 20, 3, 10, 5);
    pulse_start();
    run_frame(1'b0, -1, b, w, f, l);
    chk("xrev_white", w, 0);
    wait_idle();

    // Contiguous rows 0-19, columns 3-7
    set_cfg(0, 5, 0, 4, 3, 7);
    pulse_start();
    run_frame(1'b0, -1, b, w, f, l);
    chk("gh0_white", w, 100);
    chk("gh0_first", f, 0);
    chk("gh0_last", l, 19);
    chk("gh0_fc", 32'(frame_count), 32'd8);
    wait_idle();

    // Reset at beat 1000
    set_cfg(10, 20, 20, 3, 0, 319);
    pulse_start();
    repeat (1000) @(negedge clk);
    chk("pre_rst_valid", 32'(y_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(y_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(y_data), 32'd0);
    chk("mid_rst_flags", {29'd0, sof, eol, eof}, 32'd0);
    chk("mid_rst_fc", 32'(frame_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(y_valid), 32'd0);
    pulse_start();
    chk("restart_sof", 32'(sof), 32'd1);
    run_frame(1'b0, -1, b, w, f, l);
    chk("restart_beats", b, 3840);
    chk("restart_white", w, 960);
    chk("restart_fc", 32'(frame_count), 32'd1);

    // Truncated stripe at the bottom, and no wrap into the following frame
    wait_idle();
    set_cfg(230, 20, 20, 3, 0, 319);
    continuous = 1'b1;
    pulse_start();
    run_frame(1'b0, -1, b, w, f, l);
    chk("tr1_white", w, 160);
    chk("tr1_first", f, 230);
    chk("tr1_last", l, 239);
    count_gap(16);
    run_frame(1'b0, 0, b, w, f, l);
    chk("tr2_white", w, 160);
    chk("tr2_first", f, 230);
    chk("tr2_fc", 32'(frame_count), 32'd3);
    continuous = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
